alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational 32-bit ALU. It extends the four logic ops with a full arithmetic, compare and shift set, plus iterative unsigned multiply, divide and remainder. Results and flags are registered and returned through a valid/ready pair. It sits between the register-file read stage and writeback, and stalls issue while a multi-cycle op runs.

---
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with logic, arithmetic, compare and shift ops
// plus iterative unsigned multiply, divide and remainder.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [3:0]       op_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Z,
   output logic             equal,
   output logic             overflow,
   output logic             zero,
   output logic             div_zero,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_NOR  = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SLL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_MULU = 4'd12;
   localparam logic [3:0] OP_DIVU = 4'd13;
   localparam logic [3:0] OP_REMU = 4'd14;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      BUSY,
      DONE
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  xr;
   logic [WIDTH-1:0]  yr;
   logic [3:0]        op_r;
   logic              eq_r;
   logic              dz_r;
   logic [WIDTH-1:0]  acc;
   logic [WIDTH-1:0]  wk;
   logic [CW-1:0]     cnt;

   logic [WIDTH-1:0]  sum;
   logic [WIDTH-1:0]  diff;
   logic [SHW-1:0]    sh;
   logic [WIDTH-1:0]  sz;
   logic              sovf;
   logic              sill;
   logic [WIDTH:0]    rem_sh;
   logic              fits;
   logic [WIDTH-1:0]  mul_next;
   logic [WIDTH-1:0]  mz;
   logic              is_multi;
   logic              is_div;

   assign sum      = xr + yr;
   assign diff     = xr - yr;
   assign sh       = yr[SHW-1:0];
   assign rem_sh   = {acc, wk[WIDTH-1]};
   assign fits     = rem_sh >= {1'b0, yr};
   assign mul_next = acc + (yr[0] ? wk : '0);
   assign mz       = (op_r == OP_DIVU) ? wk : acc;
   assign is_multi = (op_code == OP_MULU) || (op_code == OP_DIVU)
                   || (op_code == OP_REMU);
   assign is_div   = (op_code == OP_DIVU) || (op_code == OP_REMU);

   // single-cycle result and flags from the latched operands
   always_comb begin
      sz   = '0;
      sovf = 1'b0;
      sill = 1'b0;
      case (op_r)
         OP_AND: sz = xr & yr;
         OP_OR:  sz = xr | yr;
         OP_XOR: sz = xr ^ yr;
         OP_NOR: sz = ~(xr | yr);
         OP_ADD: begin
            sz   = sum;
            sovf = (xr[WIDTH-1] == yr[WIDTH-1])
                 && (sum[WIDTH-1] != xr[WIDTH-1]);
         end
         OP_SUB: begin
            sz   = diff;
            sovf = (xr[WIDTH-1] != yr[WIDTH-1])
                 && (diff[WIDTH-1] != xr[WIDTH-1]);
         end
         OP_SLT: sz = {{(WIDTH-1){1'b0}}, $signed(xr) < $signed(yr)};
         OP_SRL: sz = xr >> sh;
         OP_SLL: sz = xr << sh;
         OP_SRA: sz = $signed(xr) >>> sh;
         OP_MULU, OP_DIVU, OP_REMU: sz = '0;
         default: sill = 1'b1;
      endcase
   end

   // control FSM, iterative datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Z         <= '0;
         equal     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         div_zero  <= 1'b0;
         illegal   <= 1'b0;
         xr        <= '0;
         yr        <= '0;
         op_r      <= '0;
         eq_r      <= 1'b0;
         dz_r      <= 1'b0;
         acc       <= '0;
         wk        <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xr       <= X;
                  yr       <= Y;
                  op_r     <= op_code;
                  eq_r     <= (X == Y);
                  dz_r     <= is_div && (Y == '0);
                  acc      <= '0;
                  wk       <= X;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= is_multi ? BUSY : EXEC;
               end
            end
            EXEC: begin
               Z         <= sz;
               overflow  <= sovf;
               illegal   <= sill;
               zero      <= (sz == '0);
               equal     <= eq_r;
               div_zero  <= 1'b0;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            BUSY: begin
               if (cnt == CW'(WIDTH)) begin
                  Z         <= mz;
                  overflow  <= 1'b0;
                  illegal   <= 1'b0;
                  zero      <= (mz == '0);
                  equal     <= eq_r;
                  div_zero  <= dz_r;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (op_r == OP_MULU) begin
                     acc <= mul_next;
                     wk  <= wk << 1;
                     yr  <= yr >> 1;
                  end else if (fits) begin
                     acc <= rem_sh[WIDTH-1:0] - yr;
                     wk  <= {wk[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= rem_sh[WIDTH-1:0];
                     wk  <= {wk[WIDTH-2:0], 1'b0};
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq at WIDTH 32 and 8.
// Expected results are pushed at issue and popped at the result handoff.
module tb_alu_seq;

   typedef struct {
      logic [31:0] z;
      logic [4:0]  fl;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] X = '0;
   logic [31:0] Y = '0;
   logic [3:0]  op_code = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] Z;
   logic        equal, overflow, zero, div_zero, illegal;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [7:0]  X8 = '0;
   logic [7:0]  Y8 = '0;
   logic [3:0]  op8 = '0;
   logic        out_valid8;
   logic        out_ready8 = 1'b0;
   logic [7:0]  Z8;
   logic        eq8, ov8, zr8, dz8, il8;

   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   exp_t cur;
   logic [31:0] held;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .op_code(op_code),
      .out_valid(out_valid), .out_ready(out_ready),
      .Z(Z), .equal(equal), .overflow(overflow),
      .zero(zero), .div_zero(div_zero), .illegal(illegal)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .X(X8), .Y(Y8), .op_code(op8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .Z(Z8), .equal(eq8), .overflow(ov8),
      .zero(zr8), .div_zero(dz8), .illegal(il8)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op,
                                  input logic [31:0] x,
                                  input logic [31:0] y);
      exp_t e;
      logic ov, dz, il;
      ov = 1'b0; dz = 1'b0; il = 1'b0;
      e.z = '0;
      e.lat = 1;
      case (op)
         4'd0: e.z = x & y;
         4'd1: e.z = x | y;
         4'd2: e.z = x ^ y;
         4'd3: e.z = ~(x | y);
         4'd5: begin
            e.z = x + y;
            ov = (x[31] == y[31]) && (e.z[31] != x[31]);
         end
         4'd6: begin
            e.z = x - y;
            ov = (x[31] != y[31]) && (e.z[31] != x[31]);
         end
         4'd7: e.z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd8: e.z = x >> y[4:0];
         4'd9: e.z = x << y[4:0];
         4'd10: e.z = $signed(x) >>> y[4:0];
         4'd12: begin e.z = x * y; e.lat = 33; end
         4'd13: begin
            e.lat = 33; dz = (y == 0);
            e.z = dz ? 32'hFFFF_FFFF : x / y;
         end
         4'd14: begin
            e.lat = 33; dz = (y == 0);
            e.z = dz ? x : x % y;
         end
         default: il = 1'b1;
      endcase
      e.fl = {(x == y), ov, (e.z == 0), dz, il};
      return e;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y);
      sb.push_back(model(op, x, y));
      in_valid = 1'b1; op_code = op; X = x; Y = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0; X = $urandom; Y = $urandom; op_code = 4'd5;
   endtask

   task automatic wait_result(input string tag);
      int k;
      logic rdy_seen;
      rdy_seen = 1'b0;
      for (k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         rdy_seen |= in_ready;
         if (out_valid) break;
      end
      cur = sb.pop_front();
      check({tag, " latency"}, k, cur.lat);
      check({tag, " in_ready busy"}, {31'd0, rdy_seen}, 32'd0);
      check({tag, " Z"}, Z, cur.z);
      check({tag, " flags"},
            {27'd0, equal, overflow, zero, div_zero, illegal},
            {27'd0, cur.fl});
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, " ready after"}, {31'd0, in_ready}, 32'd1);
      check({tag, " valid after"}, {31'd0, out_valid}, 32'd0);
   endtask

   task automatic run(input string tag, input logic [3:0] op,
                      input logic [31:0] x, input logic [31:0] y);
      issue(op, x, y);
      wait_result(tag);
      handoff(tag);
   endtask

   task automatic run8(input string tag, input logic [3:0] op,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] ez, input logic [4:0] efl,
                       input int lat);
      int k;
      in_valid8 = 1'b1; op8 = op; X8 = x; Y8 = y;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0; X8 = 8'h5A; Y8 = 8'hC3;
      for (k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid8) break;
      end
      check({tag, " latency"}, k, lat);
      check({tag, " Z"}, {24'd0, Z8}, {24'd0, ez});
      check({tag, " flags"}, {27'd0, eq8, ov8, zr8, dz8, il8},
            {27'd0, efl});
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      out_ready8 = 1'b0;
      check({tag, " ready after"}, {31'd0, in_ready8}, 32'd1);
   endtask

   initial begin
      logic [3:0] ops [10];
      ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
              4'd10};
      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst Z", Z, 32'd0);
      check("rst flags",
            {27'd0, equal, overflow, zero, div_zero, illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run("add ovf", 4'd5, 32'h7FFF_FFFF, 32'd1);
      check("add ovf Z const", Z, 32'h8000_0000);
      run("sub zero", 4'd6, 32'd5, 32'd5);
      run("slt", 4'd7, 32'hFFFF_FFFF, 32'd1);
      check("slt Z const", Z, 32'd1);
      run("sra", 4'd10, 32'h8000_0000, 32'h0000_0104);
      check("sra Z const", Z, 32'hF800_0000);
      run("sll", 4'd9, 32'd1, 32'd31);
      run("mulu", 4'd12, 32'h0001_0003, 32'h0000_0005);
      check("mulu Z const", Z, 32'h0005_000F);
      run("divu", 4'd13, 32'd100, 32'd7);
      check("divu Z const", Z, 32'd14);
      run("remu", 4'd14, 32'd100, 32'd7);
      run("divu0", 4'd13, 32'd9, 32'd0);
      run("remu0", 4'd14, 32'd9, 32'd0);
      run("mulu rnd", 4'd12, $urandom, $urandom);
      run("divu rnd", 4'd13, $urandom, $urandom_range(1, 1000));
      for (int i = 0; i < 8; i++)
         run("rnd", ops[$urandom_range(0, 9)], $urandom, $urandom);

      // result must stay put while the consumer stalls
      issue(4'd0, 32'hF0F0_1234, 32'hFF00_FFFF);
      wait_result("hold");
      held = cur.z;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            in_valid = 1'b1; op_code = 4'd5; X = 32'd1; Y = 32'd2;
         end
         if (i == 6) in_valid = 1'b0;
         @(posedge clk);
         #1;
         check("hold Z", Z, held);
         check("hold valid", {31'd0, out_valid}, 32'd1);
         check("hold in_ready", {31'd0, in_ready}, 32'd0);
      end
      handoff("hold");
      repeat (3) @(posedge clk);
      #1;
      check("no ghost accept", {31'd0, out_valid}, 32'd0);
      run("after hold", 4'd1, 32'h0000_00F0, 32'h0000_000F);

      // reset in the middle of a divide drops the result
      issue(4'd13, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      void'(sb.pop_front());
      check("midrst in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst Z", Z, 32'd0);
      check("midrst flags",
            {27'd0, equal, overflow, zero, div_zero, illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midrst no pulse", {31'd0, out_valid}, 32'd0);
      run("illegal", 4'd11, 32'h1234_5678, 32'h9ABC_DEF0);

      run8("w8 add", 4'd5, 8'h7F, 8'h01, 8'h80, 5'b01000, 1);
      run8("w8 sra", 4'd10, 8'h80, 8'h14, 8'hF8, 5'b00000, 1);
      run8("w8 divu", 4'd13, 8'd100, 8'd7, 8'd14, 5'b00000, 9);
      run8("w8 remu0", 4'd14, 8'd9, 8'd0, 8'd9, 5'b00010, 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
